// File: rtl/rns_pkg.sv
// ---------------------------------------------------------------------------
// rns_pkg
// Shared constants and types for the {2^n-1, 2^n, 2^n+1} residue datapath.
//   N           residue width n
//   M1/M2/M3    moduli 2^n-1, 2^n, 2^n+1; M is their product
//   CNT_W       width of the chunk-fold counter
//   state_t     forward-converter FSM encoding
//   RANGE_LO/HI signed limits of the reverse converter's legal range
// ---------------------------------------------------------------------------
package rns_pkg;

  localparam int N     = 3;
  localparam int M1    = 2**N - 1;
  localparam int M2    = 2**N;
  localparam int M3    = 2**N + 1;
  localparam int M     = M1 * M2 * M3;
  localparam int CNT_W = 2;

  // Index of the last n-bit chunk (x2) folded before the sign correction.
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_CORR = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Legal signed range of the reverse converter: -M/2 .. M/2-1.
  localparam logic signed [3*N-1:0] RANGE_LO = (3*N)'(-(M / 2));
  localparam logic signed [3*N-1:0] RANGE_HI = (3*N)'(M / 2 - 1);

endpackage

// File: rtl/signed_forward_converter_if.sv
// ---------------------------------------------------------------------------
// signed_forward_converter_if
// Operand/residue handshake bundle of the signed forward converter.
//   in_valid/in_ready/in_x           operand channel (3n-bit two's complement)
//   out_valid/out_ready              residue channel handshake
//   out_r1/out_r2/out_r3             residues mod 2^n-1, 2^n, 2^n+1
//   out_range_err                    present only with SFC_RANGE_CHECK_EN
// Modports: slave = converter side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface signed_forward_converter_if;
  import rns_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [3*N-1:0] in_x;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_r1;
  logic [N-1:0]   out_r2;
  logic [N:0]     out_r3;
`ifdef SFC_RANGE_CHECK_EN
  logic           out_range_err;
`endif

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_r1, out_r2, out_r3
`ifdef SFC_RANGE_CHECK_EN
    , output out_range_err
`endif
  );

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_r1, out_r2, out_r3
`ifdef SFC_RANGE_CHECK_EN
    , input out_range_err
`endif
  );

endinterface

// File: rtl/rns_mod_adder.sv
// ---------------------------------------------------------------------------
// rns_mod_adder
// Combinational modular add/subtract for modulus 2^n-1 or 2^n+1.
//   a, b    operands (n+1 bits); a already reduced, b < 2^n
//   sel_m3  0: modulus 2^n-1, 1: modulus 2^n+1
//   sub     0: (a+b) mod m, 1: (a-b) mod m
//   sum     reduced result (n+1 bits)
// One n+2-bit add/subtract plus a single conditional correction by the
// modulus; for 2^n-1 the compare against m folds the all-ones pattern to 0.
// ---------------------------------------------------------------------------
module rns_mod_adder
  import rns_pkg::*;
(
  input  logic [N:0] a,
  input  logic [N:0] b,
  input  logic       sel_m3,
  input  logic       sub,
  output logic [N:0] sum
);

  logic [N+1:0] modulus;
  logic [N+1:0] ext_a;
  logic [N+1:0] ext_b;
  logic [N+1:0] total;

  assign modulus = sel_m3 ? (N+2)'(M3) : (N+2)'(M1);
  assign ext_a   = {1'b0, a};
  assign ext_b   = {1'b0, b};
  assign total   = ext_a + ext_b;

  always_comb begin
    sum = '0;
    if (sub) begin
      // Borrow case wraps by adding the modulus back once.
      if (a < b) sum = (N+1)'(ext_a + modulus - ext_b);
      else       sum = (N+1)'(ext_a - ext_b);
    end else begin
      if (total >= modulus) sum = (N+1)'(total - modulus);
      else                  sum = (N+1)'(total);
    end
  end

endmodule

// File: rtl/signed_forward_converter.sv
// ---------------------------------------------------------------------------
// signed_forward_converter
// Binary-to-RNS forward converter for {2^n-1, 2^n, 2^n+1}. A 3n-bit two's
// complement operand is folded one n-bit chunk per cycle into mod 2^n-1 and
// mod 2^n+1 accumulators, then a sign correction uses 2^3n = 1 (mod 2^n-1)
// and 2^3n = -1 (mod 2^n+1): r1 = acc1 - s, r3 = acc3 + s.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  signed_forward_converter_if.slave (operand in, residues out)
// Optional feature: define SFC_RANGE_CHECK_EN to add out_range_err, set when
// the operand lies outside -M/2 .. M/2-1.
// ---------------------------------------------------------------------------
module signed_forward_converter
  import rns_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  signed_forward_converter_if.slave     bus
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3*N-1:0]   x_reg, x_next;
  logic [N:0]       acc1_reg, acc1_next;
  logic [N:0]       acc3_reg, acc3_next;
  logic [N-1:0]     r1_reg, r1_next;
  logic [N-1:0]     r2_reg, r2_next;
  logic [N:0]       r3_reg, r3_next;
`ifdef SFC_RANGE_CHECK_EN
  logic             err_reg, err_next;
`endif

  logic [2:0][N-1:0] chunk;
  logic              sign;
  logic              in_corr;
  logic [N:0]        operand;
  logic [N:0]        sum1;
  logic [N:0]        sum3;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chunk
      assign chunk[gi] = x_reg[gi*N +: N];
    end
  endgenerate

  assign sign    = x_reg[3*N-1];
  assign in_corr = (state_reg == ST_CORR);

  // Both accumulators see the same second operand: the current chunk while
  // folding, the sign bit during correction.
  assign operand = in_corr ? (N+1)'(sign) : {1'b0, chunk[cnt_reg]};

  rns_mod_adder u_add_m1 (
    .a      (acc1_reg),
    .b      (operand),
    .sel_m3 (1'b0),
    .sub    (in_corr),
    .sum    (sum1)
  );

  // Chunk x1 carries weight 2^n = -1 (mod 2^n+1), hence the subtract.
  rns_mod_adder u_add_m3 (
    .a      (acc3_reg),
    .b      (operand),
    .sel_m3 (1'b1),
    .sub    (!in_corr && (cnt_reg == CNT_W'(1))),
    .sum    (sum3)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    x_next     = x_reg;
    acc1_next  = acc1_reg;
    acc3_next  = acc3_reg;
    r1_next    = r1_reg;
    r2_next    = r2_reg;
    r3_next    = r3_reg;
`ifdef SFC_RANGE_CHECK_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_next     = bus.in_x;
          acc1_next  = '0;
          acc3_next  = '0;
          cnt_next   = '0;
          state_next = ST_FOLD;
        end
      end
      ST_FOLD: begin
        acc1_next = sum1;
        acc3_next = sum3;
        if (cnt_reg == LAST_CHUNK) begin
          cnt_next   = '0;
          state_next = ST_CORR;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_CORR: begin
        // The mod 2^n-1 result is always below 2^n-1, so its top bit is 0.
        r1_next    = sum1[N-1:0];
        r2_next    = chunk[0];
        r3_next    = sum3;
`ifdef SFC_RANGE_CHECK_EN
        err_next   = ($signed(x_reg) < RANGE_LO) || ($signed(x_reg) > RANGE_HI);
`endif
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      x_reg     <= '0;
      acc1_reg  <= '0;
      acc3_reg  <= '0;
      r1_reg    <= '0;
      r2_reg    <= '0;
      r3_reg    <= '0;
`ifdef SFC_RANGE_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      x_reg     <= x_next;
      acc1_reg  <= acc1_next;
      acc3_reg  <= acc3_next;
      r1_reg    <= r1_next;
      r2_reg    <= r2_next;
      r3_reg    <= r3_next;
`ifdef SFC_RANGE_CHECK_EN
      err_reg   <= err_next;
`endif
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.out_r1    = r1_reg;
  assign bus.out_r2    = r2_reg;
  assign bus.out_r3    = r3_reg;
`ifdef SFC_RANGE_CHECK_EN
  assign bus.out_range_err = err_reg;
`endif

endmodule

// File: tb/tb_signed_forward_converter.sv
// ---------------------------------------------------------------------------
// tb_signed_forward_converter
// Scoreboard bench: stimulus pushes expected residues computed with plain
// integer modulo arithmetic; a negedge monitor pops and compares on every
// out_valid && out_ready handshake and checks accept-to-valid latency.
// Range-error checks are compiled in with SFC_RANGE_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_signed_forward_converter;
  import rns_pkg::*;

  localparam int W  = 3 * N;
  localparam int P1 = 2**N - 1;
  localparam int P2 = 2**N;
  localparam int P3 = 2**N + 1;
  localparam int PM = P1 * P2 * P3;

  typedef struct {
    int x;
    int r1;
    int r2;
    int r3;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  signed_forward_converter_if bus ();

  signed_forward_converter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int to_signed(input logic [W-1:0] u);
    return u[W-1] ? int'(u) - 2**W : int'(u);
  endfunction

  // Reference: mathematical residues of the signed value.
  function automatic exp_t model(input int x);
    exp_t e;
    e.x   = x;
    e.r1  = ((x % P1) + P1) % P1;
    e.r2  = ((x % P2) + P2) % P2;
    e.r3  = ((x % P3) + P3) % P3;
    e.err = (x < -(PM / 2)) || (x > PM / 2 - 1);
    return e;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_wait", int'(bus.in_ready), 1);
  endtask

  task automatic send(input int x, input bit expect_out);
    wait_idle();
    bus.in_x     = W'(x);
    bus.in_valid = 1'b1;
    if (expect_out) sb.push_back(model(x));
    @(posedge clk); #1;
    accept_cyc   = cyc;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && !prev_valid)
        check("latency", cyc - accept_cyc, 4);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("r1", int'(bus.out_r1), mon_e.r1);
          check("r2", int'(bus.out_r2), mon_e.r2);
          check("r3", int'(bus.out_r3), mon_e.r3);
`ifdef SFC_RANGE_CHECK_EN
          check("range_err", int'(bus.out_range_err), int'(mon_e.err));
`endif
          $display("txn x=%0d r=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", mon_e.x,
                   bus.out_r1, bus.out_r2, bus.out_r3, mon_e.r1, mon_e.r2, mon_e.r3);
        end
      end
    end
    prev_valid = bus.out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dir[] = '{0, 100, -1, -252, 251, 252, -256, 255, 7, -9};
    int k;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_r1", int'(bus.out_r1), 0);
    check("rst_r2", int'(bus.out_r2), 0);
    check("rst_r3", int'(bus.out_r3), 0);
`ifdef SFC_RANGE_CHECK_EN
    check("rst_range_err", int'(bus.out_range_err), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed values including range boundaries.
    foreach (dir[i]) send(dir[i], 1'b1);

    // Consumer stall: outputs frozen, new operands ignored.
    wait_idle();
    bus.out_ready = 1'b0;
    send(100, 1'b1);
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("stall_valid_seen", int'(bus.out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_x     = W'($urandom);
      @(negedge clk);
      check("stall_out_valid", int'(bus.out_valid), 1);
      check("stall_in_ready", int'(bus.in_ready), 0);
      check("stall_r1", int'(bus.out_r1), 2);
      check("stall_r2", int'(bus.out_r2), 4);
      check("stall_r3", int'(bus.out_r3), 1);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset while folding chunk x1: result must never appear.
    send(-77, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    send(100, 1'b1);

    // Back-to-back random operands.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] u;
      u = W'($urandom);
      send(to_signed(u), 1'b1);
    end

    // Drain the scoreboard.
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
